// File: rtl/e0_keystream_xor.sv
// e0_keystream_xor: packs the serial E0 keystream into DATA_W-bit words, queues them in a
//   KS_DEPTH-entry FIFO and XORs each queued word with one plaintext word.
// Latency: a word is in the FIFO one clk after its last bit; dout is registered one clk
//   after the din transfer. Backpressure: ks_ready drops while the FIFO is full (no bypass),
//   and din_ready needs a queued word and a free or draining output register.
// Build option: define E0_WARMUP_DISCARD_EN to drop the first WARMUP keystream bits after
//   reset or restart.
module e0_keystream_xor #(
  parameter int DATA_W   = 8,
  parameter int KS_DEPTH = 2,
  parameter int WARMUP   = 200
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          restart,
  input  logic                          ks_bit,
  input  logic                          ks_valid,
  output logic                          ks_ready,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(KS_DEPTH):0]     ks_level
);

  localparam int PW = $clog2(KS_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(KS_DEPTH);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);

  // Elaboration-time guard: the pointer arithmetic relies on a power-of-two depth.
  if (KS_DEPTH < 2 || (KS_DEPTH & (KS_DEPTH - 1)) != 0 || WARMUP < 0) begin : g_bad_param
    $error("e0_keystream_xor: KS_DEPTH must be a power of 2 >= 2 and WARMUP >= 0");
  end

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic [DATA_W-1:0] mem_q [KS_DEPTH];
  logic [DATA_W-1:0] mem_d [KS_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;

  logic ks_fire, din_fire, out_fire, pack_en, push;

  assign ks_ready   = !rst && !restart && (lvl_q < DEPTH_LVL);
  assign din_ready  = !rst && !restart && (lvl_q != '0) && (!dv_q || dout_ready);
  assign ks_fire    = ks_valid && ks_ready;
  assign din_fire   = din_valid && din_ready;
  assign out_fire   = dv_q && dout_ready;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign ks_level   = lvl_q;

`ifdef E0_WARMUP_DISCARD_EN
  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WCW-1:0] WARMUP_LD = WCW'(WARMUP);

  logic [WCW-1:0] wu_q, wu_d;
  logic           warm;

  assign warm    = (wu_q != '0);
  // Accepted bits only reach the packer once the warmup count has run out.
  assign pack_en = ks_fire && !warm;

  // Warmup countdown: one step per accepted bit, reloaded by restart.
  always_comb begin
    wu_d = wu_q;
    if (restart) begin
      wu_d = WARMUP_LD;
    end else if (ks_fire && warm) begin
      wu_d = wu_q - 1'b1;
    end
  end

  // Warmup counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wu_q <= WARMUP_LD;
    end else begin
      wu_q <= wu_d;
    end
  end
`else
  assign pack_en = ks_fire;
`endif

  // Packer: LSB-first shift-in; the completing bit pushes the whole word on the same edge.
  always_comb begin
    cnt_d  = cnt_q;
    pack_d = pack_q;
    push   = 1'b0;
    if (restart) begin
      cnt_d  = '0;
      pack_d = '0;
    end else if (pack_en) begin
      pack_d[cnt_q] = ks_bit;
      if (cnt_q == LAST_BIT) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Word FIFO: write at wr, pop at rd on each din transfer; restart empties it.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (restart) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = pack_d;
        wr_d        = wr_q + 1'b1;
      end
      if (din_fire) begin
        rd_d = rd_q + 1'b1;
      end
      case ({push, din_fire})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
  end

  // Output register: load ciphertext on a din transfer, clear valid once drained.
  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    if (restart) begin
      dv_d = 1'b0;
    end else if (din_fire) begin
      dout_d = din ^ mem_q[rd_q];
      dv_d   = 1'b1;
    end else if (out_fire) begin
      dv_d = 1'b0;
    end
  end

  // State registers for packer, FIFO and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pack_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      for (int i = 0; i < KS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      mem_q  <= mem_d;
    end
  end

endmodule
